// File: rtl/input_thread_sched.sv
// Round-robin load scheduler for the shared realign/core_input path of a
// multi-core sha512 unit. It tracks per-thread input-buffer occupancy and
// issues one load at a time to a thread that wants a block and has an empty
// buffer. The issued load is closed by in_done.
module input_thread_sched #(
  parameter int N_CORES       = 4,
  parameter int N_THREADS     = 4 * N_CORES,
  parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     sched_en,
  input  logic [N_THREADS-1:0]     thread_want,
  input  logic [N_THREADS-1:0]     rd_done,
  input  logic                     in_done,
  output logic                     start,
  output logic [N_THREADS_MSB:0]   thread_num,
  output logic [N_THREADS-1:0]     thread_grant,
  output logic                     busy,
  output logic [N_THREADS-1:0]     buf_full,
  output logic                     err
);

  localparam int THR_W = N_THREADS_MSB + 1;

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [THR_W-1:0]     last;
  logic [N_THREADS-1:0] eligible;
  logic [THR_W-1:0]     pick;
  logic                 found;
  logic                 issue;
  logic                 load_done;
  logic [N_THREADS-1:0] buf_full_nxt;
  logic                 err_nxt;
  int                   idx;

  assign eligible = thread_want & ~buf_full;

  // Round-robin pick: first eligible thread scanning upward from last+1, wrapping modulo N_THREADS.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_THREADS; k++) begin
      idx = (int'(last) + k) % N_THREADS;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = THR_W'(idx);
      end
    end
  end

  // Next-state logic: issue a load from IDLE, close it on in_done in BUSY.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    load_done = 1'b0;
    case (state)
      IDLE: begin
        if (sched_en && found) begin
          state_nxt = BUSY;
          issue     = 1'b1;
        end
      end
      BUSY: begin
        if (in_done) begin
          state_nxt = IDLE;
          load_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Occupancy and error update: a completed load's set wins over a same-cycle consume.
  always_comb begin
    buf_full_nxt = buf_full & ~rd_done;
    if (load_done) buf_full_nxt[thread_num] = 1'b1;
    err_nxt = err
            | (|(rd_done & ~buf_full))
            | (in_done && (state == IDLE))
            | (load_done && rd_done[thread_num]);
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Registered outputs and scheduler bookkeeping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      start        <= 1'b0;
      thread_grant <= '0;
      thread_num   <= '0;
      busy         <= 1'b0;
      buf_full     <= '0;
      err          <= 1'b0;
      last         <= THR_W'(N_THREADS - 1);
    end else begin
      start        <= issue;
      thread_grant <= issue ? (N_THREADS'(1) << pick) : '0;
      if (issue) begin
        thread_num <= pick;
        busy       <= 1'b1;
      end else if (load_done) begin
        busy       <= 1'b0;
      end
      if (load_done) last <= thread_num;
      buf_full <= buf_full_nxt;
      err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_input_thread_sched.sv
// Directed bench for input_thread_sched: reset, round-robin order, wrap-around,
// occupancy tracking, protocol errors, mid-load reset and sched_en gating.
module tb_input_thread_sched;

  localparam int NT = 16;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          sched_en = 1'b0;
  logic [NT-1:0] thread_want = '0;
  logic [NT-1:0] rd_done = '0;
  logic          in_done = 1'b0;
  logic          start;
  logic [3:0]    thread_num;
  logic [NT-1:0] thread_grant;
  logic          busy;
  logic [NT-1:0] buf_full;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;
  bit seen;

  input_thread_sched #(.N_CORES(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .sched_en(sched_en), .thread_want(thread_want),
    .rd_done(rd_done), .in_done(in_done), .start(start), .thread_num(thread_num),
    .thread_grant(thread_grant), .busy(busy), .buf_full(buf_full), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
  endtask

  task automatic wait_start(input int maxc, output bit s);
    s = 1'b0;
    for (int i = 0; i < maxc && !s; i++) begin
      tick();
      if (start) s = 1'b1;
    end
  endtask

  // Wait for a grant to thread exp, hold the load a few cycles, then close it.
  task automatic load_thread(input int exp, input int gap, input string tag);
    bit s;
    wait_start(40, s);
    check({tag, "_start"}, s, 1);
    check({tag, "_num"}, thread_num, exp);
    check({tag, "_grant"}, thread_grant, 32'(1) << exp);
    repeat (gap) tick();
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
    check({tag, "_full"}, buf_full[exp], 1);
  endtask

  initial begin
    // Test 1: reset state and first grant
    sched_en = 1'b1;
    thread_want = 16'h0001;
    #2;
    check("rst_start", start, 0);
    check("rst_grant", thread_grant, 0);
    check("rst_busy", busy, 0);
    check("rst_full", buf_full, 0);
    check("rst_err", err, 0);
    tick();
    RST_N = 1'b1;
    tick();
    check("t1_start", start, 1);
    check("t1_grant", thread_grant, 16'h0001);
    check("t1_num", thread_num, 0);
    check("t1_busy", busy, 1);
    tick();
    check("t1_pulse", start, 0);
    check("t1_gpulse", thread_grant, 0);
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
    check("t1_full", buf_full, 16'h0001);
    check("t1_idle", busy, 0);
    wait_start(10, seen);
    check("t1_nostart", seen, 0);

    // Test 2: full round-robin sweep, stall, then release of one buffer
    do_reset();
    thread_want = 16'hFFFF;
    for (int i = 0; i < NT; i++) load_thread(i, 16, $sformatf("t2_rr%0d", i));
    wait_start(10, seen);
    check("t2_stall", seen, 0);
    check("t2_allfull", buf_full, 16'hFFFF);
    rd_done = 16'h0010;
    tick();
    rd_done = '0;
    check("t2_rd4", buf_full, 16'hFFEF);
    load_thread(4, 2, "t2_re4");
    check("t2_err", err, 0);

    // Test 3: wrap-around from last=5
    do_reset();
    thread_want = 16'h0020;
    load_thread(5, 2, "t3_l5");
    thread_want = 16'h0204;
    load_thread(9, 2, "t3_g9");
    load_thread(2, 2, "t3_g2");

    // Test 4: protocol errors
    thread_want = '0;
    check("t4_noerr", err, 0);
    rd_done = 16'h0008;
    tick();
    rd_done = '0;
    check("t4_err", err, 1);
    check("t4_full", buf_full, 16'h0224);
    repeat (3) tick();
    check("t4_sticky", err, 1);
    do_reset();
    check("t4_rsterr", err, 0);
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
    check("t4_idle_done", err, 1);
    check("t4_idle_full", buf_full, 0);

    // Test 5: reset while a load is in flight
    do_reset();
    thread_want = 16'hFFFF;
    wait_start(10, seen);
    check("t5_start", seen, 1);
    repeat (3) tick();
    check("t5_busy", busy, 1);
    #2;
    RST_N = 1'b0;
    #1;
    check("t5_abusy", busy, 0);
    check("t5_astart", start, 0);
    check("t5_agrant", thread_grant, 0);
    check("t5_anum", thread_num, 0);
    check("t5_afull", buf_full, 0);
    check("t5_aerr", err, 0);
    tick();
    tick();
    RST_N = 1'b1;
    load_thread(0, 2, "t5_first");

    // Test 6: sched_en gating
    do_reset();
    sched_en = 1'b0;
    thread_want = 16'h00F0;
    wait_start(10, seen);
    check("t6_gated", seen, 0);
    sched_en = 1'b1;
    wait_start(10, seen);
    check("t6_en", seen, 1);
    check("t6_num4", thread_num, 4);
    sched_en = 1'b0;
    tick();
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
    check("t6_full4", buf_full, 16'h0010);
    check("t6_idle", busy, 0);
    wait_start(8, seen);
    check("t6_hold", seen, 0);
    sched_en = 1'b1;
    wait_start(10, seen);
    check("t6_resume", seen, 1);
    check("t6_num5", thread_num, 5);
    // same-cycle set and consume on the thread being loaded: set wins, error flagged
    in_done = 1'b1;
    rd_done = 16'h0020;
    tick();
    in_done = 1'b0;
    rd_done = '0;
    check("t6_setwins", buf_full, 16'h0030);
    check("t6_seterr", err, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
